// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants for the sequential shift-add multiplier
// Purpose: operand width, RV32M multiply op encodings (funct3[1:0]) and FSM states.
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/multiplier.sv
// rtl/multiplier.sv - radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
// Purpose: multiplies magnitudes one bit per cycle, then re-applies the sign and
//          returns the requested 32-bit half of the 64-bit product.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   start  in   one-cycle request, samples op/x/y (restarts any operation)
//   op     in   2-bit op select (MUL, MULH, MULHSU, MULHU)
//   x      in   multiplicand (rs1)
//   y      in   multiplier (rs2)
//   busy   out  calculation in progress
//   valid  out  p holds the result of the last accepted start
//   p      out  result word
// Build option: MUL_EARLY_OUT_EN - leave RUN as soon as the remaining multiplier is zero.
module multiplier
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] p
);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     p_q, p_d;

  // Operand conditioning: MUL treats both sides as unsigned since the low word
  // is sign-independent; the magnitude of -2^31 fits as 32-bit unsigned.
  logic            x_signed, y_signed, x_neg, y_neg;
  logic [XLEN-1:0] x_mag, y_mag;
  logic [2*XLEN-1:0] prod;

  assign x_signed = (op == OP_MULH) || (op == OP_MULHSU);
  assign y_signed = (op == OP_MULH);
  assign x_neg    = x_signed & x[XLEN-1];
  assign y_neg    = y_signed & y[XLEN-1];
  assign x_mag    = x_neg ? ({XLEN{1'b0}} - x) : x;
  assign y_mag    = y_neg ? ({XLEN{1'b0}} - y) : y;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    p_d      = p_q;
    prod     = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;

    case (state_q)
      ST_RUN: begin
`ifdef MUL_EARLY_OUT_EN
        if (mplier_q == '0) begin
          state_d = ST_FIX;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          // Exit right after consuming the highest set bit.
          if (cnt_q == 5'd31 || mplier_q[XLEN-1:1] == '0) state_d = ST_FIX;
        end
`else
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
`endif
      end
      ST_FIX: begin
        p_d     = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // A new request wins over whatever is in flight.
    if (start) begin
      valid_d  = 1'b0;
      busy_d   = 1'b1;
      op_d     = op;
      mcand_d  = {{XLEN{1'b0}}, x_mag};
      mplier_d = y_mag;
      neg_d    = x_neg ^ y_neg;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      p_q      <= p_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign p     = p_q;

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - scoreboard bench for multiplier against a 64-bit arithmetic reference
module tb_multiplier;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] x, y;
  logic        busy, valid;
  logic [31:0] p;

  multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .valid (valid),
    .p     (p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] p;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: full 64-bit product of the operands extended per op semantics.
  function automatic logic [31:0] ref_p(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, r;
    ae = (o == OP_MULH || o == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    be = (o == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    r  = ae * be;
    return (o == OP_MUL) ? r[31:0] : r[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
    logic [31:0] m;
    int hi;
    m  = (o == OP_MULH && b[31]) ? (32'd0 - b) : b;
    hi = 0;
    if (m == 32'd0) return 2;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    return 2 + hi;
`else
    return 33;
`endif
  endfunction

  // Inputs driven #1 after a rising edge; the start is sampled on the next edge (T0).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.p = ref_p(o, a, b);
      e.lat = exp_lat(o, b);
      e.t0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(valid === 1'b1 && busy === 1'b0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL wait_done actual=timeout required=valid_within_100");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every valid rise; also checks p holds while busy.
  logic        valid_prev = 1'b0;
  logic [31:0] p_hold = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      chk("p_hold_while_busy", p, p_hold);
    end else if (busy === 1'b0) begin
      p_hold = p;
    end
    if (valid === 1'b1 && valid_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=valid required=no_valid");
      end else begin
        e = sb.pop_front();
        chk("p", p, e.p);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_at_valid", {31'd0, busy}, 32'd0);
      end
    end
    valid_prev = valid;
  end

  initial begin
    logic [31:0] specials [5];
    logic [31:0] a, b;
    logic [1:0]  o;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'h8000_0000;
    specials[3] = 32'hFFFF_FFFF; specials[4] = 32'h7FFF_FFFF;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
    idle(3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_p", p, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of RUN aborts without a result.
    issue(OP_MUL, 32'd3, 32'd5, 1'b0);
    idle(9);
    rst_n = 1'b0;
    idle(1);
    chk("midrun_busy", {31'd0, busy}, 32'd0);
    chk("midrun_valid", {31'd0, valid}, 32'd0);
    chk("midrun_p", p, 32'd0);
    rst_n = 1'b1;
    idle(40);
    chk("midrun_no_valid", {31'd0, valid}, 32'd0);

    // Start and reset on the same edge: reset wins.
    start = 1'b1; op = OP_MUL; x = 32'd4; y = 32'd4; rst_n = 1'b0;
    idle(1);
    start = 1'b0; rst_n = 1'b1;
    chk("start_vs_reset_busy", {31'd0, busy}, 32'd0);

    issue(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 1'b1); wait_done();
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 1'b1); wait_done();
    issue(OP_MULHU,  32'h8000_0000, 32'h8000_0000, 1'b1); wait_done();
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
    issue(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();

    // Restart: the abandoned MULH must not produce a valid.
    issue(OP_MULH, 32'd2, 32'd3, 1'b0);
    idle(4);
    issue(OP_MUL, 32'd6, 32'd7, 1'b1);
    wait_done();
    idle(40);

    // Early-out boundary operands (identical p in either build).
    issue(OP_MUL, 32'd9, 32'd0, 1'b1);           wait_done();
    issue(OP_MUL, 32'd9, 32'd1, 1'b1);           wait_done();
    issue(OP_MUL, 32'd9, 32'h8000_0000, 1'b1);   wait_done();
    issue(OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();

    // Randomized traffic with back-to-back starts, gaps and restarts.
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        issue(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        idle($urandom_range(0, 30));
      end
      issue(o, a, b, 1'b1);
      wait_done();
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
